hyperram_rd_capture_ctrl: RTL and testbench
===========================================

Name: hyperram_rd_capture_ctrl

Overview:
- Sequences the HyperRAM read-data capture path. The DDR input flops on DQ[7:0] and RWDS present rise/fall sample pairs once per clk.
- Skips the initial access latency, then qualifies each sample pair with RWDS and packs it into a 16-bit word. Counts the burst and flags RWDS timeouts.
- Sits between the DDR input flops and the HyperRAM command sequencer / user read port.

Parameters:
- DW, 8, DQ lane width; word output is 2*DW.
- LAT_W, 5, width of the latency-count input.
- TIMEOUT, 64, max consecutive clk cycles without a valid RWDS strobe before an error; range 2..255.

Ports:
- clk  in  1  capture clock, same clock that drives the DDR input flops
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin a read burst; ignored unless busy=0
- abort  in  1  terminate any burst; return to IDLE next cycle
- burst_len  in  8  number of words; 0 means 256; sampled on accepted start
- lat_cycles  in  LAT_W  clk cycles to discard after start; sampled on accepted start
- dq_ris  in  DW  rising-edge DQ sample
- dq_fal  in  DW  falling-edge DQ sample
- rwds_ris  in  1  rising-edge RWDS sample
- rwds_fal  in  1  falling-edge RWDS sample
- rd_data  out  2*DW  captured word, {dq_ris, dq_fal}
- rd_valid  out  1  rd_data valid this cycle
- rd_last  out  1  with rd_valid, marks the final word of the burst
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse when a burst ends by timeout

Behaviour:
- Reset: state=IDLE; rd_data=0, rd_valid=0, rd_last=0, busy=0, err_timeout=0; all counters=0.
- Strobe: a pair is valid when rwds_ris=1 and rwds_fal=0. All other RWDS combinations are stall cycles.
- IDLE:
  - start=1 loads word_cnt=(burst_len==0 ? 256 : burst_len) (9-bit) and lat_cnt=lat_cycles.
  - Next state: WAIT_LAT if lat_cycles!=0, else CAPTURE.
  - busy rises the cycle after start.
- WAIT_LAT:
  - lat_cnt decrements each cycle; DQ/RWDS are ignored.
  - At lat_cnt==1, go to CAPTURE; exactly lat_cycles cycles are spent here.
- CAPTURE:
  - On a valid strobe, register rd_data={dq_ris,dq_fal} and assert rd_valid the next cycle (1-cycle latency). Decrement word_cnt; clear stall_cnt.
  - On a stall cycle, increment stall_cnt.
  - When a valid strobe arrives with word_cnt==1, rd_last=1 with that word and the state goes to IDLE. busy falls in the same cycle rd_last is asserted.
  - The first-word wait and mid-burst RWDS pauses share stall_cnt.
  - When stall_cnt reaches TIMEOUT-1 and the current cycle is also a stall, go to IDLE and pulse err_timeout next cycle. No rd_last is issued; words already delivered stand.
- Outputs: rd_valid, rd_last and err_timeout are single-cycle, registered pulses. rd_data holds its last value when rd_valid=0.
- abort:
  - Has priority over everything except rst. State goes to IDLE; no rd_valid from the abort cycle onward.
  - No err_timeout; counters cleared.
  - abort and start in the same cycle: abort wins and start is dropped.
- start while busy=1 is ignored; no queueing.
- rst mid-burst behaves identically to the reset state above; in-flight words are dropped.
- Word count is exact: extra valid strobes after the last word are ignored because the state is IDLE.
- No combinational path from any input to any output.

Test Plan:
- Basic burst: start with burst_len=4, lat_cycles=3, data pairs 0x11/0x22, 0x33/0x44, 0x55/0x66, 0x77/0x88 with valid strobes from cycle 4.
  - Expect rd_valid on 4 consecutive cycles with words 0x1122, 0x3344, 0x5566, 0x7788.
  - rd_last only on 0x7788; busy low the same cycle; no stray valids.
- RWDS pause: burst_len=3, 5 stall cycles between words 1 and 2 → exactly 3 words, in order; err_timeout=0.
- Timeout: TIMEOUT=8, burst_len=4, only 2 valid strobes then RWDS held 0 → 2 words, then err_timeout pulses once.
  - The pulse comes 8 stall cycles after the last strobe; busy=0 after; rd_last never asserted.
- Full-length burst: burst_len=0, lat_cycles=0, continuous strobes → exactly 256 rd_valid pulses, rd_last on the 256th.
  - A start pulsed mid-burst is ignored.
- Abort/reset: abort asserted after word 2 of an 8-word burst → no further rd_valid, busy=0 next cycle, err_timeout=0.
  - Repeat with rst instead: all outputs at reset values.
  - A fresh start afterwards completes a 2-word burst correctly.
- Priority: abort and start in the same cycle from IDLE → busy stays 0. RWDS pattern rwds_ris=1, rwds_fal=1 is not counted as a strobe.

Source files
------------

// File: rtl/hyperram_rd_capture_ctrl.sv
// HyperRAM read-data capture controller: skips access latency, qualifies DDR
// sample pairs with RWDS, packs them into words, counts the burst, flags timeouts.
module hyperram_rd_capture_ctrl #(
  parameter int DW      = 8,
  parameter int LAT_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      burst_len,
  input  logic [LAT_W-1:0] lat_cycles,
  input  logic [DW-1:0]   dq_ris,
  input  logic [DW-1:0]   dq_fal,
  input  logic            rwds_ris,
  input  logic            rwds_fal,
  output logic [2*DW-1:0] rd_data,
  output logic            rd_valid,
  output logic            rd_last,
  output logic            busy,
  output logic            err_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LAT = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  localparam logic [7:0]       STALL_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO    = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE     = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic [8:0]      word_cnt_r, word_cnt_s;
  logic [LAT_W-1:0] lat_cnt_r, lat_cnt_s;
  logic [7:0]      stall_cnt_r, stall_cnt_s;
  logic [2*DW-1:0] rd_data_r, rd_data_s;
  logic            rd_valid_r, rd_valid_s;
  logic            rd_last_r, rd_last_s;
  logic            err_timeout_r, err_timeout_s;
  logic            busy_r;
  logic            strobe_s;

  // Only the rise=1/fall=0 RWDS pattern carries a data pair; anything else stalls.
  assign strobe_s = rwds_ris & ~rwds_fal;

  // Next-state, counter and output-pulse logic.
  always_comb begin
    state_s       = state_r;
    word_cnt_s    = word_cnt_r;
    lat_cnt_s     = lat_cnt_r;
    stall_cnt_s   = stall_cnt_r;
    rd_data_s     = rd_data_r;
    rd_valid_s    = 1'b0;
    rd_last_s     = 1'b0;
    err_timeout_s = 1'b0;
    if (abort) begin
      state_s     = IDLE;
      word_cnt_s  = 9'd0;
      lat_cnt_s   = LAT_ZERO;
      stall_cnt_s = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            word_cnt_s  = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
            lat_cnt_s   = lat_cycles;
            stall_cnt_s = 8'd0;
            state_s     = (lat_cycles != LAT_ZERO) ? WAIT_LAT : CAPTURE;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_LAT: begin
          if (lat_cnt_r == LAT_ONE) begin
            lat_cnt_s = LAT_ZERO;
            state_s   = CAPTURE;
          end else begin
            lat_cnt_s = lat_cnt_r - LAT_ONE;
          end
        end
        CAPTURE: begin
          if (strobe_s) begin
            rd_data_s   = {dq_ris, dq_fal};
            rd_valid_s  = 1'b1;
            stall_cnt_s = 8'd0;
            word_cnt_s  = word_cnt_r - 9'd1;
            if (word_cnt_r == 9'd1) begin
              rd_last_s = 1'b1;
              state_s   = IDLE;
            end else begin
              state_s = CAPTURE;
            end
          end else if (stall_cnt_r == STALL_LIMIT) begin
            // First-word wait and mid-burst pauses share this budget.
            err_timeout_s = 1'b1;
            stall_cnt_s   = 8'd0;
            word_cnt_s    = 9'd0;
            state_s       = IDLE;
          end else begin
            stall_cnt_s = stall_cnt_r + 8'd1;
          end
        end
        default: begin
          state_s     = IDLE;
          word_cnt_s  = 9'd0;
          lat_cnt_s   = LAT_ZERO;
          stall_cnt_s = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      word_cnt_r    <= 9'd0;
      lat_cnt_r     <= LAT_ZERO;
      stall_cnt_r   <= 8'd0;
      rd_data_r     <= {(2*DW){1'b0}};
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      word_cnt_r    <= word_cnt_s;
      lat_cnt_r     <= lat_cnt_s;
      stall_cnt_r   <= stall_cnt_s;
      rd_data_r     <= rd_data_s;
      rd_valid_r    <= rd_valid_s;
      rd_last_r     <= rd_last_s;
      err_timeout_r <= err_timeout_s;
      busy_r        <= (state_s != IDLE);
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign rd_last     = rd_last_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_hyperram_rd_capture_ctrl.sv
// Self-checking bench for hyperram_rd_capture_ctrl: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_hyperram_rd_capture_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  burst_len;
  logic [4:0]  lat_cycles;
  logic [7:0]  dq_ris, dq_fal;
  logic        rwds_ris, rwds_fal;
  logic [15:0] rd_data;
  logic        rd_valid, rd_last, busy, err_timeout;

  int checks = 0;
  int errors = 0;

  hyperram_rd_capture_ctrl #(.DW(8), .LAT_W(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burst_len(burst_len), .lat_cycles(lat_cycles),
    .dq_ris(dq_ris), .dq_fal(dq_fal), .rwds_ris(rwds_ris), .rwds_fal(rwds_fal),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: a burst is "active" with some latency left, some words
  // left and a run of quiet (non-strobe) cycles.
  bit          m_active = 1'b0;
  int          m_lat_left = 0, m_words_left = 0, m_quiet = 0;
  logic [15:0] m_data = 16'h0000;
  bit          m_valid = 1'b0, m_last = 1'b0, m_err = 1'b0, m_busy = 1'b0;

  task automatic model_step(input logic r, s, a, input logic [7:0] bl,
                            input logic [4:0] lt, input logic [7:0] dr, df,
                            input logic wr, wf);
    m_valid = 1'b0; m_last = 1'b0; m_err = 1'b0;
    if (r) begin
      m_active = 1'b0; m_data = 16'h0000;
    end else if (a) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1; m_lat_left = lt; m_quiet = 0;
        m_words_left = (bl == 8'd0) ? 256 : int'(bl);
      end
    end else if (m_lat_left > 0) begin
      m_lat_left--;
    end else if (wr && !wf) begin
      m_data = {dr, df}; m_valid = 1'b1; m_quiet = 0; m_words_left--;
      if (m_words_left == 0) begin m_last = 1'b1; m_active = 1'b0; end
    end else begin
      m_quiet++;
      if (m_quiet == TMO) begin m_err = 1'b1; m_active = 1'b0; end
    end
    m_busy = m_active;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic step(input logic r, s, a, input logic [7:0] bl, input logic [4:0] lt,
                      input logic [7:0] dr, df, input logic wr, wf, input bit cmp);
    rst = r; start = s; abort = a; burst_len = bl; lat_cycles = lt;
    dq_ris = dr; dq_fal = df; rwds_ris = wr; rwds_fal = wf;
    @(posedge clk);
    model_step(r, s, a, bl, lt, dr, df, wr, wf);
    #1;
    if (cmp) begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      chk("rd_last", {31'd0, rd_last}, {31'd0, m_last});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
      chk("rd_data", {16'd0, rd_data}, {16'd0, m_data});
    end
  endtask

  task automatic go(input logic [7:0] bl, input logic [4:0] lt);
    step(1'b0, 1'b1, 1'b0, bl, lt, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic strb(input logic [7:0] dr, df);
    step(1'b0, 1'b0, 1'b0, 8'd0, 5'd0, dr, df, 1'b1, 1'b0, 1'b1);
  endtask
  task automatic stall();
    step(1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic r, s, a; logic [7:0] bl; logic [4:0] lt; logic [7:0] dr, df; logic wr, wf;
    logic ev, el, eb, ee; logic [15:0] ed;
  } vec_t;

  vec_t vecs[15];
  int   n_valid, n_last, n_err, last_at, n_stall;

  initial begin
    //           r     s     a     bl     lt     dr     df     wr    wf    ev    el    eb    ee    ed
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd4, 5'd3, 8'hEE, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'hEE, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'hEE, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'hEE, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1122};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3344};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h55, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5566};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h77, 8'h88, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7788};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h99, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7788};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'd2, 5'd0, 8'h99, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7788};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'h99, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7788};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd1, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7788};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'hBB, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7788};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'hDD, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hDDEE};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].bl, vecs[i].lt,
           vecs[i].dr, vecs[i].df, vecs[i].wr, vecs[i].wf, 1'b0);
      chk($sformatf("vec%0d.rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d.rd_last", i), {31'd0, rd_last}, {31'd0, vecs[i].el});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].eb});
      chk($sformatf("vec%0d.err_timeout", i), {31'd0, err_timeout}, {31'd0, vecs[i].ee});
      chk($sformatf("vec%0d.rd_data", i), {16'd0, rd_data}, {16'd0, vecs[i].ed});
    end

    // RWDS pause of 5 cycles between words 1 and 2.
    go(8'd3, 5'd0);
    n_valid = 0; n_err = 0;
    strb(8'hA1, 8'hB1); n_valid += int'(rd_valid);
    for (int i = 0; i < 5; i++) begin stall(); n_valid += int'(rd_valid); n_err += int'(err_timeout); end
    strb(8'hA2, 8'hB2); n_valid += int'(rd_valid);
    strb(8'hA3, 8'hB3); n_valid += int'(rd_valid);
    chk("pause.words", n_valid, 3);
    chk("pause.err", n_err, 0);
    chk("pause.last_word", {16'd0, rd_data}, 32'h0000A3B3);

    // Timeout after two words.
    go(8'd4, 5'd2);
    stall(); stall();
    n_valid = 0; n_err = 0; n_last = 0; n_stall = 0;
    strb(8'hC1, 8'hD1); n_valid += int'(rd_valid);
    strb(8'hC2, 8'hD2); n_valid += int'(rd_valid); n_last += int'(rd_last);
    while (n_err == 0 && n_stall < 20) begin
      stall(); n_stall++; n_err += int'(err_timeout); n_last += int'(rd_last);
    end
    chk("tmo.words", n_valid, 2);
    chk("tmo.stalls_to_err", n_stall, TMO);
    chk("tmo.busy_after", {31'd0, busy}, 32'd0);
    stall(); n_err += int'(err_timeout);
    chk("tmo.err_pulses", n_err, 1);
    chk("tmo.no_last", n_last, 0);

    // Full 256-word burst with an ignored mid-burst start.
    go(8'd0, 5'd0);
    n_valid = 0; n_last = 0; last_at = 0;
    for (int i = 0; i < 300 && n_valid < 256; i++) begin
      step(1'b0, (i == 100), 1'b0, 8'd5, 5'd0, 8'(i), 8'(~i), 1'b1, 1'b0, 1'b1);
      if (rd_valid) n_valid++;
      if (rd_last) begin n_last++; last_at = n_valid; end
    end
    strb(8'h01, 8'h02);
    n_valid += int'(rd_valid);
    chk("full.words", n_valid, 256);
    chk("full.last_count", n_last, 1);
    chk("full.last_at", last_at, 256);

    // Abort after word 2 of an 8-word burst, with a strobe present on the abort cycle.
    go(8'd8, 5'd1);
    stall(); strb(8'hE1, 8'hF1); strb(8'hE2, 8'hF2);
    step(1'b0, 1'b0, 1'b1, 8'd0, 5'd0, 8'hE3, 8'hF3, 1'b1, 1'b0, 1'b1);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.valid", {31'd0, rd_valid}, 32'd0);
    n_valid = 0; n_err = 0;
    for (int i = 0; i < 12; i++) begin strb(8'hE4, 8'hF4); n_valid += int'(rd_valid); n_err += int'(err_timeout); end
    chk("abort.no_more_words", n_valid, 0);
    chk("abort.no_err", n_err, 0);

    // Same with reset mid-burst, then a fresh 2-word burst.
    go(8'd8, 5'd0);
    strb(8'h61, 8'h71); strb(8'h62, 8'h72);
    step(1'b1, 1'b0, 1'b0, 8'd0, 5'd0, 8'h63, 8'h73, 1'b1, 1'b0, 1'b1);
    chk("rst.data", {16'd0, rd_data}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    go(8'd2, 5'd0);
    n_valid = 0; n_last = 0;
    strb(8'h81, 8'h91); n_valid += int'(rd_valid); n_last += int'(rd_last);
    strb(8'h82, 8'h92); n_valid += int'(rd_valid); n_last += int'(rd_last);
    chk("fresh.words", n_valid, 2);
    chk("fresh.last", n_last, 1);
    chk("fresh.data", {16'd0, rd_data}, 32'h00008292);

    // Randomized traffic with varying RWDS density.
    for (int seg = 0; seg < 20; seg++) begin
      int dens;
      dens = $urandom_range(30, 100);
      for (int i = 0; i < 200; i++) begin
        logic [7:0] bl;
        bl = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 99) == 0, bl, 5'($urandom_range(0, 6)),
             8'($urandom), 8'($urandom),
             $urandom_range(0, 99) < dens, $urandom_range(0, 9) == 0, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
